// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory stage plus MEM/WB pipeline register.
// Byte/half/word loads and stores with sign or zero extension, a data-memory
// latency of MEM_LATENCY wait cycles with a stall handshake, and a writeback flush.
// Optional macro MEMSTAGE_MISALIGN_TRAP_EN: flag misaligned accesses (MisalignW)
// instead of masking the low address bits to natural alignment.
module mem_stage_lsu #(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int MEM_LATENCY = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteM,
  input  logic            MemReadM,
  input  logic            MemWriteM,
  input  logic [1:0]      ResultSrcM,
  input  logic [2:0]      Funct3M,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] WriteDataM,
  input  logic [4:0]      RD_M,
  input  logic [XLEN-1:0] PCPlus4M,
  input  logic            FlushW,
  output logic            StallM,
  output logic            RegWriteW,
  output logic [1:0]      ResultSrcW,
  output logic [XLEN-1:0] ALUResultW,
  output logic [XLEN-1:0] ReadDataW,
  output logic [4:0]      RD_W,
`ifdef MEMSTAGE_MISALIGN_TRAP_EN
  output logic            MisalignW,
`endif
  output logic [XLEN-1:0] PCPlus4W
);

  localparam int ADDR_W = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_M1 = 4'((MEM_LATENCY > 0) ? MEM_LATENCY - 1 : 0);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state, stateNext;
  logic [3:0]          cnt, cntNext;
  logic [XLEN-1:0]     mem [DEPTH_WORDS];

  logic                memop, isLoad, isStore, isByte, isHalf, isUns, misalign, complete;
  logic [1:0]          off;
  logic [ADDR_W-1:0]   wordIdx;
  logic [XLEN-1:0]     loadData, storeData;
  logic [XLEN/8-1:0]   byteEn;

  // Extract the addressed byte/half and extend it to XLEN.
  function automatic logic [XLEN-1:0] formatLoad(input logic [XLEN-1:0] word,
                                                 input logic [1:0] sel,
                                                 input logic byteOp,
                                                 input logic halfOp,
                                                 input logic unsOp);
    logic signed [7:0]      sb;
    logic signed [15:0]     sh;
    logic signed [XLEN-1:0] ext;
    sb = word[{sel, 3'b000} +: 8];
    sh = word[{sel[1], 4'b0000} +: 16];
    if (byteOp)
      ext = unsOp ? XLEN'($unsigned(sb)) : XLEN'(sb);
    else if (halfOp)
      ext = unsOp ? XLEN'($unsigned(sh)) : XLEN'(sh);
    else
      ext = word;
    return ext;
  endfunction

  // Decode access size, alignment and byte lanes of the M instruction.
  always_comb begin
    memop   = MemReadM | MemWriteM;
    isStore = MemWriteM;
    isLoad  = MemReadM & ~MemWriteM;
    isByte  = (Funct3M[1:0] == 2'b00);
    isHalf  = (Funct3M[1:0] == 2'b01);
    isUns   = Funct3M[2];
    wordIdx = ALUResultM[ADDR_W+1:2];
`ifdef MEMSTAGE_MISALIGN_TRAP_EN
    misalign = memop & ((isHalf & ALUResultM[0]) |
                        (~isByte & ~isHalf & (ALUResultM[1:0] != 2'b00)));
    off      = ALUResultM[1:0];
`else
    misalign = 1'b0;
    off      = isByte ? ALUResultM[1:0] : (isHalf ? {ALUResultM[1], 1'b0} : 2'b00);
`endif
    storeData = isByte ? {(XLEN/8){WriteDataM[7:0]}} :
                (isHalf ? {(XLEN/16){WriteDataM[15:0]}} : WriteDataM);
    byteEn = '0;
    if (isByte) begin
      byteEn[off] = 1'b1;
    end else if (isHalf) begin
      byteEn[{off[1], 1'b0}] = 1'b1;
      byteEn[{off[1], 1'b1}] = 1'b1;
    end else begin
      byteEn = '1;
    end
    loadData = formatLoad(mem[wordIdx], off, isByte, isHalf, isUns);
    StallM   = memop & ~misalign &
               ~((MEM_LATENCY == 0) | ((state == BUSY) & (cnt == 4'd0)));
    complete = memop & ~misalign & ~StallM;
  end

  // Wait-cycle FSM: count down the access latency; a flush aborts it.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    case (state)
      IDLE: if (memop & ~misalign & (MEM_LATENCY > 0)) begin
        stateNext = BUSY;
        cntNext   = LAT_M1;
      end
      BUSY: if (cnt != 4'd0) cntNext = cnt - 4'd1;
            else             stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    if (FlushW) begin
      stateNext = IDLE;
      cntNext   = 4'd0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // Store commit: only on the completion edge, masked to the addressed lanes.
  always_ff @(posedge clk) begin
    if (complete & isStore & ~FlushW & ~rst) begin
      for (int b = 0; b < XLEN/8; b++)
        if (byteEn[b]) mem[wordIdx][8*b +: 8] <= storeData[8*b +: 8];
    end
  end

  // ---- MEM/WB boundary: bubble on reset, flush or stall, else capture ----
  always_ff @(posedge clk) begin
    if (rst | FlushW | StallM) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
      ALUResultW <= '0;
      ReadDataW  <= '0;
      RD_W       <= 5'd0;
      PCPlus4W   <= '0;
`ifdef MEMSTAGE_MISALIGN_TRAP_EN
      MisalignW  <= 1'b0;
`endif
    end else begin
      RegWriteW  <= RegWriteM & ~(misalign & isLoad);
      ResultSrcW <= ResultSrcM;
      ALUResultW <= ALUResultM;
      ReadDataW  <= (isLoad & ~misalign) ? loadData : '0;
      RD_W       <= RD_M;
      PCPlus4W   <= PCPlus4M;
`ifdef MEMSTAGE_MISALIGN_TRAP_EN
      MisalignW  <= misalign;
`endif
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: two instances (latency 0 and 3) against a byte-array model.
module tb_mem_stage_lsu;
  int lat[2] = '{0, 3};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        RegWriteM[2], MemReadM[2], MemWriteM[2], FlushW[2];
  logic [1:0]  ResultSrcM[2];
  logic [2:0]  Funct3M[2];
  logic [31:0] ALUResultM[2], WriteDataM[2], PCPlus4M[2];
  logic [4:0]  RD_M[2];
  logic        StallM[2], RegWriteW[2];
  logic [1:0]  ResultSrcW[2];
  logic [31:0] ALUResultW[2], ReadDataW[2], PCPlus4W[2];
  logic [4:0]  RD_W[2];
`ifdef MEMSTAGE_MISALIGN_TRAP_EN
  logic        MisalignW[2];
`endif

  mem_stage_lsu #(.XLEN(32), .DEPTH_WORDS(1024), .MEM_LATENCY(0)) u0 (
    .clk(clk), .rst(rst), .RegWriteM(RegWriteM[0]), .MemReadM(MemReadM[0]),
    .MemWriteM(MemWriteM[0]), .ResultSrcM(ResultSrcM[0]), .Funct3M(Funct3M[0]),
    .ALUResultM(ALUResultM[0]), .WriteDataM(WriteDataM[0]), .RD_M(RD_M[0]),
    .PCPlus4M(PCPlus4M[0]), .FlushW(FlushW[0]), .StallM(StallM[0]),
    .RegWriteW(RegWriteW[0]), .ResultSrcW(ResultSrcW[0]), .ALUResultW(ALUResultW[0]),
    .ReadDataW(ReadDataW[0]), .RD_W(RD_W[0]),
`ifdef MEMSTAGE_MISALIGN_TRAP_EN
    .MisalignW(MisalignW[0]),
`endif
    .PCPlus4W(PCPlus4W[0]));

  mem_stage_lsu #(.XLEN(32), .DEPTH_WORDS(1024), .MEM_LATENCY(3)) u3 (
    .clk(clk), .rst(rst), .RegWriteM(RegWriteM[1]), .MemReadM(MemReadM[1]),
    .MemWriteM(MemWriteM[1]), .ResultSrcM(ResultSrcM[1]), .Funct3M(Funct3M[1]),
    .ALUResultM(ALUResultM[1]), .WriteDataM(WriteDataM[1]), .RD_M(RD_M[1]),
    .PCPlus4M(PCPlus4M[1]), .FlushW(FlushW[1]), .StallM(StallM[1]),
    .RegWriteW(RegWriteW[1]), .ResultSrcW(ResultSrcW[1]), .ALUResultW(ALUResultW[1]),
    .ReadDataW(ReadDataW[1]), .RD_W(RD_W[1]),
`ifdef MEMSTAGE_MISALIGN_TRAP_EN
    .MisalignW(MisalignW[1]),
`endif
    .PCPlus4W(PCPlus4W[1]));

  typedef struct packed {
    logic        rw;
    logic [1:0]  rs;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        mis;
  } wrec_t;

  wrec_t nextW[2], expW[2];
  logic  expStall[2];
  bit    checking = 0;
  int    errors = 0, checks = 0;
  logic [7:0] mm [2][4096];

  always @(posedge clk) begin
    expW[0] <= nextW[0];
    expW[1] <= nextW[1];
  end

  task automatic chk(string name, int d, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s dut%0d actual=%h required=%h", name, d, act, req);
    end
  endtask

  // Per-cycle comparison of both DUTs against the model's expectations.
  always @(negedge clk) begin
    if (checking) begin
      for (int d = 0; d < 2; d++) begin
        chk("StallM", d, 32'(StallM[d]), 32'(expStall[d]));
        chk("RegWriteW", d, 32'(RegWriteW[d]), 32'(expW[d].rw));
        chk("ResultSrcW", d, 32'(ResultSrcW[d]), 32'(expW[d].rs));
        chk("ALUResultW", d, ALUResultW[d], expW[d].alu);
        chk("ReadDataW", d, ReadDataW[d], expW[d].rdata);
        chk("RD_W", d, 32'(RD_W[d]), 32'(expW[d].rd));
        chk("PCPlus4W", d, PCPlus4W[d], expW[d].pc);
`ifdef MEMSTAGE_MISALIGN_TRAP_EN
        chk("MisalignW", d, 32'(MisalignW[d]), 32'(expW[d].mis));
`endif
      end
    end
  end

  task automatic nop(int d);
    RegWriteM[d] = 0; MemReadM[d] = 0; MemWriteM[d] = 0; FlushW[d] = 0;
    ResultSrcM[d] = 0; Funct3M[d] = 0; ALUResultM[d] = 0; WriteDataM[d] = 0;
    RD_M[d] = 0; PCPlus4M[d] = 0;
    expStall[d] = 0;
    nextW[d] = '0;
  endtask

  // Issue one instruction to DUT d, hold it through its stall cycles and
  // update the model. evAt: cycle index at which FlushW (or rst) is pulsed.
  task automatic issue(int d, bit rw, bit mr, bit mw, logic [2:0] f3,
                       logic [31:0] addr, logic [31:0] wdata, logic [4:0] rd,
                       int evAt, bit useRst);
    int size, a, stalls;
    bit uns, memop, isLd, mis, ev;
    logic [31:0] v;
    wrec_t res;
    memop = mr | mw;
    isLd  = mr & ~mw;
    size  = (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
    uns   = f3[2];
    a     = int'(addr % 4096);
    mis   = 0;
`ifdef MEMSTAGE_MISALIGN_TRAP_EN
    if (memop && (a % size) != 0) mis = 1;
`else
    a = a - (a % size);
`endif
    v = 0;
    for (int i = 0; i < size; i++) v |= 32'(mm[d][a+i]) << (8*i);
    if (!uns && size < 4 && v[8*size-1]) v |= ~((32'd1 << (8*size)) - 1);
    res.rw    = rw && !(mis && isLd);
    res.rs    = 2'($urandom);
    res.alu   = addr;
    res.rdata = (isLd && !mis) ? v : 32'd0;
    res.rd    = rd;
    res.pc    = $urandom;
    res.mis   = mis;
    RegWriteM[d] = rw; MemReadM[d] = mr; MemWriteM[d] = mw; ResultSrcM[d] = res.rs;
    Funct3M[d] = f3; ALUResultM[d] = addr; WriteDataM[d] = wdata; RD_M[d] = rd;
    PCPlus4M[d] = res.pc;
    stalls = (memop && !mis) ? lat[d] : 0;
    for (int c = 0; c <= stalls; c++) begin
      ev = (c == evAt);
      expStall[d] = (c < stalls);
      FlushW[d] = ev && !useRst;
      rst = ev && useRst;
      nextW[d] = (ev || c < stalls) ? wrec_t'(0) : res;
      @(posedge clk); #1;
      FlushW[d] = 0;
      rst = 0;
      if (ev) break;
      if (c == stalls && mw && !mis)
        for (int i = 0; i < size; i++) mm[d][a+i] = wdata[8*i +: 8];
    end
    nop(d);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4096; i++) mm[d][i] = 8'h00;
      nop(d);
    end
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    checking = 1;

    // Give the test region a known (zero) content.
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < 16; w++)
        issue(d, 0, 0, 1, 3'b010, 32'(w*4), 32'd0, 5'd0, -1, 0);

    // Latency 0: word, byte and alias accesses.
    issue(0, 0, 0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 5'd0, -1, 0);
    issue(0, 1, 1, 0, 3'b010, 32'h10, 32'h0, 5'd3, -1, 0);
    chk("lit_lw10", 0, ReadDataW[0], 32'hDEADBEEF);
    issue(0, 0, 0, 1, 3'b000, 32'h13, 32'h80, 5'd0, -1, 0);
    issue(0, 1, 1, 0, 3'b000, 32'h13, 32'h0, 5'd4, -1, 0);
    chk("lit_lb13", 0, ReadDataW[0], 32'hFFFFFF80);
    issue(0, 1, 1, 0, 3'b100, 32'h13, 32'h0, 5'd4, -1, 0);
    chk("lit_lbu13", 0, ReadDataW[0], 32'h00000080);
    issue(0, 1, 1, 0, 3'b010, 32'h10, 32'h0, 5'd5, -1, 0);
    chk("lit_lw10b", 0, ReadDataW[0], 32'h80ADBEEF);
    issue(0, 1, 1, 0, 3'b010, 32'h1010, 32'h0, 5'd5, -1, 0);
    chk("lit_alias", 0, ReadDataW[0], 32'h80ADBEEF);
    // Flush at a completion edge in IDLE suppresses the store.
    issue(0, 0, 0, 1, 3'b010, 32'h14, 32'hCAFEF00D, 5'd0, 0, 0);
    issue(0, 1, 1, 0, 3'b010, 32'h14, 32'h0, 5'd6, -1, 0);
    chk("lit_flush0", 0, ReadDataW[0], 32'h0);

    // Latency 3.
    issue(1, 0, 0, 1, 3'b010, 32'h20, 32'h12345678, 5'd0, -1, 0);
    issue(1, 1, 1, 0, 3'b010, 32'h20, 32'h0, 5'd7, -1, 0);
    chk("lit_lw20", 1, ReadDataW[1], 32'h12345678);
    chk("lit_rd20", 1, 32'(RD_W[1]), 32'd7);
    chk("lit_rw20", 1, 32'(RegWriteW[1]), 32'd1);
    issue(1, 0, 0, 1, 3'b010, 32'h30, 32'h55, 5'd0, 1, 0);
    #1;
    chk("lit_flushstall", 1, 32'(StallM[1]), 32'd0);
    issue(1, 1, 1, 0, 3'b010, 32'h30, 32'h0, 5'd8, -1, 0);
    chk("lit_lw30", 1, ReadDataW[1], 32'h0);
    issue(1, 0, 0, 1, 3'b010, 32'h30, 32'h0000A1B2, 5'd0, -1, 0);
    issue(1, 1, 1, 0, 3'b001, 32'h31, 32'h0, 5'd9, -1, 0);
`ifdef MEMSTAGE_MISALIGN_TRAP_EN
    chk("lit_mis_flag", 1, 32'(MisalignW[1]), 32'd1);
    chk("lit_mis_rw", 1, 32'(RegWriteW[1]), 32'd0);
    chk("lit_mis_data", 1, ReadDataW[1], 32'h0);
`else
    chk("lit_lh31", 1, ReadDataW[1], 32'hFFFFA1B2);
`endif
    // Reset in the middle of a BUSY access.
    issue(1, 1, 1, 0, 3'b010, 32'h20, 32'h0, 5'd10, 2, 1);
    #1;
    chk("lit_rst_stall", 1, 32'(StallM[1]), 32'd0);
    chk("lit_rst_rw", 1, 32'(RegWriteW[1]), 32'd0);
    issue(1, 1, 1, 0, 3'b010, 32'h20, 32'h0, 5'd11, -1, 0);
    chk("lit_keep", 1, ReadDataW[1], 32'h12345678);

    // Randomized traffic on both instances.
    for (int n = 0; n < 160; n++) begin
      int d, ev;
      d  = n % 2;
      ev = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, lat[d])) : -1;
      issue(d, 1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom),
            32'($urandom_range(0, 63)) | (32'($urandom_range(0, 3)) << 12),
            $urandom, 5'($urandom), ev, 0);
    end

    repeat (2) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Parametrised successor to the current MEM stage: memory stage plus MEM/WB pipeline register for the RISC-V pipeline core.
- Adds byte/halfword/word load-store with sign/zero extension and a configurable data-memory latency with a stall handshake.
- Adds a writeback-bubble flush input.
- Sits between the execute-cycle register and the writeback mux; holds its own data-memory array.

Parameters:
- XLEN, 32, data/address width.
- DEPTH_WORDS, 1024, data memory depth in XLEN words; must be a power of two. ADDR_W = log2(DEPTH_WORDS).
- MEM_LATENCY, 0, extra wait cycles per memory access (0 = single-cycle, range 0..15).

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  synchronous reset, active-high
- RegWriteM  in  1  register-write enable of M instruction
- MemReadM  in  1  load
- MemWriteM  in  1  store
- ResultSrcM  in  2  writeback select, passed through
- Funct3M  in  3  access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU; others treated as word
- ALUResultM  in  XLEN  effective address / ALU result
- WriteDataM  in  XLEN  store data (low bits used for SB/SH)
- RD_M  in  5  destination register
- PCPlus4M  in  XLEN  passed through
- FlushW  in  1  force bubble into MEM/WB
- StallM  out  1  combinational; upstream must hold all M inputs and stop earlier stages while high
- RegWriteW, ResultSrcW, ALUResultW, ReadDataW, RD_W, PCPlus4W  out  1/2/XLEN/XLEN/5/XLEN  registered MEM/WB outputs
- MisalignW  out  1  registered misaligned-access flag (only with optional feature)

Behaviour:
- Reset: all W outputs 0, FSM IDLE, wait counter 0. Memory array contents are not cleared. Reset overrides FlushW and aborts any pending access.
- memop = MemReadM | MemWriteM.
- Misalign (feature on): half with addr[0]=1, or word with addr[1:0]!=0. A misaligned memop never stalls and performs no array access.
- Word index = ALUResultM[ADDR_W+1:2]. Higher address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- FSM states:
  - IDLE: memop, aligned, MEM_LATENCY>0 -> BUSY with cnt=MEM_LATENCY-1. Otherwise the op completes this cycle.
  - BUSY: cnt!=0 -> cnt-1. cnt==0 -> complete, go to IDLE.
- StallM = memop & aligned & ~(MEM_LATENCY==0 | (state==BUSY & cnt==0)). A memop therefore stalls exactly MEM_LATENCY cycles.
- Completion edge:
  - W registers capture the M inputs; ReadDataW gets the formatted load data.
  - Stores write the array exactly once, on the completion edge.
  - During stall cycles W loads a bubble (all W outputs 0).
- Non-memops pass through with 1-cycle latency and no stall. Back-to-back memops each pay the full latency.
- Store lanes:
  - SB writes byte addr[1:0] only.
  - SH writes half addr[1] only.
  - SW writes the full word.
  - Other bytes are preserved.
- Load formatting: LB/LH sign-extend to XLEN; LBU/LHU zero-extend; LW raw word. ReadDataW=0 for non-loads and misaligned loads.
- Load and store in the same instruction (both set): treat as store; ReadDataW=0.
- FlushW=1 at an edge: W loads a bubble. If BUSY, the access is aborted: state -> IDLE, no store committed, StallM drops next cycle.
- FlushW in IDLE at a completion edge also suppresses that store.

Optional Feature:
- Macro MEMSTAGE_MISALIGN_TRAP_EN.
- Defined: misaligned detection as above; MisalignW port present, set with the bubble-free W capture of the offending instruction. RegWriteW is forced to 0 for a misaligned load.
- Undefined: MisalignW port absent; low address bits are masked to natural alignment (half: addr[0]=0; word: addr[1:0]=0) and the access proceeds normally with full latency.

Test Plan:
- MEM_LATENCY=0:
  - SW 0xDEADBEEF @0x10, then LW @0x10 -> ReadDataW=0xDEADBEEF one cycle later, StallM never high.
  - SB 0x80 @0x13, then LB @0x13 -> 0xFFFFFF80 and LBU @0x13 -> 0x00000080. LW @0x10 -> 0x80ADBEEF.
- MEM_LATENCY=3, LW @0x20 holding 0x12345678:
  - StallM high 3 cycles with RegWriteW=0 each cycle.
  - Next edge: RegWriteW=1, ReadDataW=0x12345678, RD_W = the issued RD_M.
- MEM_LATENCY=3, SW 0x55 @0x30 with FlushW pulsed in the 2nd stall cycle -> StallM low next cycle, W bubble, later LW @0x30 returns the old value 0.
- With MEMSTAGE_MISALIGN_TRAP_EN, LH @0x31 -> no stall, MisalignW=1, RegWriteW=0, ReadDataW=0. Without the macro, the same access reads half @0x30.
- rst=1 asserted mid-BUSY -> next cycle all W outputs 0, StallM=0. Address 0x1000+0x10 with DEPTH_WORDS=1024 aliases 0x10.
